// File: rtl/tlc_phase_arbiter.sv
// Request latch and phase scheduler in front of the 5-phase traffic light sequencer.
// Winner priority: emergency preempt, then lowest aged phase, then round-robin from rr_ptr.
module tlc_phase_arbiter #(
  parameter int NPH       = 5,
  parameter int WAIT_W    = 4,
  parameter int AGE_LIMIT = 12
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NPH-1:0] req_i,
  input  logic           preempt_valid_i,
  input  logic [2:0]     preempt_phase_i,
  output logic           grant_valid_o,
  output logic [2:0]     grant_phase_o,
  input  logic           grant_ready_i,
  input  logic           phase_done_i,
  output logic           abort_req_o,
  output logic [NPH-1:0] pending_o,
  output logic [NPH-1:0] aged_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_SERVE = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] AGE_LIM  = WAIT_W'(AGE_LIMIT);
  localparam logic [2:0]        LAST_PH  = 3'(NPH - 1);

  state_e            state_q;
  logic              grant_valid_q;
  logic [2:0]        grant_phase_q;
  logic              abort_q;
  logic [2:0]        rr_ptr_q;
  logic [NPH-1:0]    pending_q, pending_d;
  logic [WAIT_W-1:0] wait_q [NPH];
  logic [WAIT_W-1:0] wait_d [NPH];

  logic              pre_ok_s, accept_s, done_s, cand_s;
  logic [2:0]        win_s;
  logic [3:0]        rr_idx_s;
  logic [NPH-1:0]    is_gp_s, serving_s, pre_hit_s, aged_s;

  assign pre_ok_s = preempt_valid_i && ({1'b0, preempt_phase_i} < 4'(NPH));
  assign accept_s = (state_q == S_OFFER) && grant_ready_i;
  assign done_s   = (state_q == S_SERVE) && phase_done_i;

  // Per-phase decode of the current grant, preempt target and aging
  always_comb begin
    is_gp_s   = '0;
    serving_s = '0;
    pre_hit_s = '0;
    aged_s    = '0;
    for (int i = 0; i < NPH; i++) begin
      is_gp_s[i]   = (grant_phase_q == 3'(i));
      serving_s[i] = (state_q == S_SERVE) && is_gp_s[i];
      pre_hit_s[i] = pre_ok_s && (preempt_phase_i == 3'(i));
      aged_s[i]    = pending_q[i] && (wait_q[i] >= AGE_LIM);
    end
  end

  // Pending latch and wait counters; acceptance beats a same-edge request
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NPH; i++) begin
      wait_d[i] = wait_q[i];
      if (done_s && is_gp_s[i]) begin
        pending_d[i] = req_i[i];
      end else if (accept_s && is_gp_s[i]) begin
        pending_d[i] = 1'b0;
      end else if ((req_i[i] || pre_hit_s[i]) && !serving_s[i]) begin
        pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = pending_q[i];
      end
      if (accept_s && is_gp_s[i]) begin
        wait_d[i] = '0;
      end else if (pending_q[i] && !serving_s[i] && (wait_q[i] != WAIT_MAX)) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  // Winner selection; loops run downward so the last hit is the preferred one
  always_comb begin
    cand_s   = 1'b0;
    win_s    = 3'd0;
    rr_idx_s = 4'd0;
    if (pre_ok_s) begin
      cand_s = 1'b1;
      win_s  = preempt_phase_i;
    end else if (|aged_s) begin
      cand_s = 1'b1;
      for (int i = NPH - 1; i >= 0; i--) begin
        win_s = aged_s[i] ? 3'(i) : win_s;
      end
    end else begin
      cand_s = |pending_q;
      for (int k = NPH - 1; k >= 0; k--) begin
        rr_idx_s = {1'b0, rr_ptr_q} + 4'(k);
        rr_idx_s = (rr_idx_s >= 4'(NPH)) ? (rr_idx_s - 4'(NPH)) : rr_idx_s;
        win_s    = pending_q[rr_idx_s[2:0]] ? rr_idx_s[2:0] : win_s;
      end
    end
  end

  // Pending and wait-counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      for (int i = 0; i < NPH; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      wait_q    <= wait_d;
    end
  end

  // Handshake FSM with registered grant, abort and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_phase_q <= 3'd0;
      abort_q       <= 1'b0;
      rr_ptr_q      <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (cand_s) begin
            state_q       <= S_OFFER;
            grant_valid_q <= 1'b1;
            grant_phase_q <= win_s;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OFFER: begin
          if (grant_ready_i) begin
            state_q       <= S_SERVE;
            grant_valid_q <= 1'b0;
          end else begin
            state_q <= S_OFFER;
          end
        end
        S_SERVE: begin
          if (phase_done_i) begin
            state_q  <= S_IDLE;
            abort_q  <= 1'b0;
            rr_ptr_q <= (grant_phase_q == LAST_PH) ? 3'd0 : (grant_phase_q + 3'd1);
          end else begin
            abort_q <= pre_ok_s && (preempt_phase_i != grant_phase_q);
          end
        end
        default: begin
          state_q       <= S_IDLE;
          grant_valid_q <= 1'b0;
          abort_q       <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_phase_o = grant_phase_q;
  assign abort_req_o   = abort_q;
  assign pending_o     = pending_q;
  assign aged_o        = aged_s;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Self-checking bench for tlc_phase_arbiter: per-scenario tasks plus a grant scoreboard
// that compares each accepted phase against the queue of expected grants.
module tb_tlc_phase_arbiter;
  localparam int NPH = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NPH-1:0] req;
  logic           preempt_valid;
  logic [2:0]     preempt_phase;
  logic           grant_valid;
  logic [2:0]     grant_phase;
  logic           grant_ready;
  logic           phase_done;
  logic           abort_req;
  logic [NPH-1:0] pending;
  logic [NPH-1:0] aged;
  logic           busy;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q [$];

  // Wider counters so that a full round-robin sweep does not trip aging
  tlc_phase_arbiter #(.NPH(NPH), .WAIT_W(5), .AGE_LIMIT(20)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .preempt_valid_i(preempt_valid), .preempt_phase_i(preempt_phase),
    .grant_valid_o(grant_valid), .grant_phase_o(grant_phase), .grant_ready_i(grant_ready),
    .phase_done_i(phase_done), .abort_req_o(abort_req),
    .pending_o(pending), .aged_o(aged), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted grant must match the next expected phase
  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (rst_n && grant_valid && grant_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: accepted phase=%0d required=none", grant_phase);
      end else begin
        e = exp_q.pop_front();
        if (grant_phase !== e) begin
          bad++;
          $display("FAIL sb_grant: accepted phase=%0d required=%0d", grant_phase, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; preempt_valid = 1'b0; preempt_phase = 3'd0;
    grant_ready = 1'b0; phase_done = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_offer(output bit ok);
    int n = 0;
    while (!grant_valid && n < 40) begin
      tick();
      n++;
    end
    ok = grant_valid;
  endtask

  task automatic accept();
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
  endtask

  task automatic finish_phase();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({grant_valid, grant_phase, abort_req, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outs: gv/gp/abort/busy=%b required=000000", {grant_valid, grant_phase, abort_req, busy});
    end
    total++;
    if ({pending, aged} !== 10'b0) begin
      bad++;
      $display("FAIL reset_pend: pending/aged=%b required=0", {pending, aged});
    end
    total++;
    if (dut.rr_ptr_q !== 3'd0) begin
      bad++;
      $display("FAIL reset_rr: rr_ptr=%0d required=0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_single();
    do_reset();
    phase_done = 1'b1; grant_ready = 1'b1;
    tick();
    phase_done = 1'b0; grant_ready = 1'b0;
    total++;
    if ({busy, grant_valid} !== 2'b00) begin
      bad++;
      $display("FAIL ignore_idle: busy/gv=%b required=00", {busy, grant_valid});
    end
    exp_q.push_back(3'd4);
    req = 5'b10000;
    tick();
    req = '0;
    total++;
    if ({pending, grant_valid} !== 6'b10000_0) begin
      bad++;
      $display("FAIL single_pend: pending/gv=%b required=100000", {pending, grant_valid});
    end
    tick();
    total++;
    if ({grant_valid, grant_phase} !== 4'b1_100) begin
      bad++;
      $display("FAIL single_offer: gv/gp=%b required=1100", {grant_valid, grant_phase});
    end
    accept();
    total++;
    if ({grant_valid, busy, pending} !== 7'b0_1_00000) begin
      bad++;
      $display("FAIL single_serve: gv/busy/pending=%b required=0100000", {grant_valid, busy, pending});
    end
    tick();
    finish_phase();
    total++;
    if ({busy, dut.rr_ptr_q} !== 4'b0_000) begin
      bad++;
      $display("FAIL single_done: busy/rr=%b required=0000", {busy, dut.rr_ptr_q});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    bit ok;
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(order[k]);
    req = 5'b11111;
    grant_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_offer(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rr_offer%0d: grant_valid=0 required=1", k);
      end
      tick();
      tick();
      tick();
      finish_phase();
      total++;
      if (pending[order[k]] !== 1'b1) begin
        bad++;
        $display("FAIL rr_repend%0d: pending[%0d]=%b required=1", k, order[k], pending[order[k]]);
      end
    end
    req = '0;
    grant_ready = 1'b0;
  endtask

  task automatic test_aging();
    bit ok;
    do_reset();
    exp_q.push_back(3'd0);
    req = 5'b00001;
    tick();
    req = '0;
    wait_offer(ok);
    accept();
    req = 5'b01010;
    tick();
    req = '0;
    repeat (22) tick();
    total++;
    if ({aged, pending} !== 10'b01010_01010) begin
      bad++;
      $display("FAIL aging_bits: aged/pending=%b required=0101001010", {aged, pending});
    end
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    finish_phase();
    wait_offer(ok);
    accept();
    total++;
    if (aged !== 5'b01000) begin
      bad++;
      $display("FAIL aging_left: aged=%b required=01000", aged);
    end
    finish_phase();
    wait_offer(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL aging_second: grant_valid=0 required=1");
    end
    accept();
    finish_phase();
    tick();
    total++;
    if ({busy, pending} !== 6'b0) begin
      bad++;
      $display("FAIL aging_drain: busy/pending=%b required=000000", {busy, pending});
    end
  endtask

  task automatic test_preempt();
    bit ok;
    do_reset();
    exp_q.push_back(3'd0);
    req = 5'b00011;
    tick();
    req = '0;
    wait_offer(ok);
    accept();
    preempt_valid = 1'b1; preempt_phase = 3'd4;
    tick();
    total++;
    if ({abort_req, pending} !== 6'b1_10010) begin
      bad++;
      $display("FAIL pre_abort: abort/pending=%b required=110010", {abort_req, pending});
    end
    tick();
    exp_q.push_back(3'd4);
    finish_phase();
    total++;
    if ({abort_req, busy} !== 2'b00) begin
      bad++;
      $display("FAIL pre_done: abort/busy=%b required=00", {abort_req, busy});
    end
    wait_offer(ok);
    accept();
    tick();
    total++;
    if (abort_req !== 1'b0) begin
      bad++;
      $display("FAIL pre_same: abort=%b required=0", abort_req);
    end
    preempt_valid = 1'b0;
    exp_q.push_back(3'd1);
    finish_phase();
    wait_offer(ok);
    accept();
    preempt_valid = 1'b1; preempt_phase = 3'd7;
    tick();
    tick();
    total++;
    if ({abort_req, pending} !== 6'b0) begin
      bad++;
      $display("FAIL pre_invalid: abort/pending=%b required=000000", {abort_req, pending});
    end
    finish_phase();
    tick();
    tick();
    total++;
    if ({grant_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL pre_invalid_idle: gv/busy=%b required=00", {grant_valid, busy});
    end
    preempt_valid = 1'b0;
  endtask

  task automatic test_offer_stability();
    bit ok;
    do_reset();
    exp_q.push_back(3'd2);
    req = 5'b00100;
    tick();
    req = '0;
    wait_offer(ok);
    preempt_valid = 1'b1; preempt_phase = 3'd4;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({grant_valid, grant_phase} !== 4'b1_010) begin
        bad++;
        $display("FAIL offer_hold%0d: gv/gp=%b required=1010", k, {grant_valid, grant_phase});
      end
    end
    exp_q.push_back(3'd4);
    accept();
    tick();
    total++;
    if (abort_req !== 1'b1) begin
      bad++;
      $display("FAIL offer_abort: abort=%b required=1", abort_req);
    end
    finish_phase();
    wait_offer(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL offer_next: grant_valid=0 required=1");
    end
    preempt_valid = 1'b0;
    accept();
    finish_phase();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    exp_q.push_back(3'd0);
    req = 5'b00001;
    tick();
    req = '0;
    wait_offer(ok);
    accept();
    preempt_valid = 1'b1; preempt_phase = 3'd3;
    req = 5'b00110;
    tick();
    total++;
    if ({busy, abort_req, pending} !== 7'b1_1_01110) begin
      bad++;
      $display("FAIL mid_pre: busy/abort/pending=%b required=1101110", {busy, abort_req, pending});
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({grant_valid, abort_req, busy, pending, aged} !== 13'b0) begin
      bad++;
      $display("FAIL mid_async: gv/abort/busy/pending/aged=%b required=0", {grant_valid, abort_req, busy, pending, aged});
    end
    req = '0;
    preempt_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({busy, grant_valid, pending} !== 7'b0) begin
      bad++;
      $display("FAIL mid_release: busy/gv/pending=%b required=0", {busy, grant_valid, pending});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_aging();
    test_preempt();
    test_offer_stability();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: remaining=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlc_phase_arbiter.md
Name: tlc_phase_arbiter

Overview:
- Request latch and phase scheduler that sits in front of the 5-phase traffic light sequencer.
- Phases: 0=ES+WS, 1=ES+EL, 2=WS+WL, 3=EL+WL, 4=NS.
- Latches per-phase sensor demand and picks the next phase to serve: emergency preemption first, then aged (starving) phases, then round-robin.
- Hands the chosen phase to the sequencer through a valid/ready handshake and tracks it until the sequencer reports completion, i.e. end of all-red.

Parameters:
- NPH, 5, number of phases; 2..8.
- WAIT_W, 4, width of each per-phase wait counter.
- AGE_LIMIT, 12, wait count at or above which a pending phase is aged; must be ≤ 2^WAIT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  NPH  level demand per phase (OR of conflicting-free sensors)
- preempt_valid  in  1  emergency preemption request, level
- preempt_phase  in  3  phase to preempt to; values ≥ NPH are ignored
- grant_valid  out  1  offer of the next phase to the sequencer
- grant_phase  out  3  offered/served phase index
- grant_ready  in  1  sequencer is in all-red and accepts the offer
- phase_done  in  1  one-cycle pulse: served phase finished yellow+all-red
- abort_req  out  1  asks the sequencer to cut the current green short (preemption)
- pending  out  NPH  latched demand bits
- aged  out  NPH  pending phases whose wait counter ≥ AGE_LIMIT
- busy  out  1  high in OFFER or SERVE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pending=0, all wait counters=0, rr_ptr=0, grant_valid=0, grant_phase=0, abort_req=0. A reset mid-OFFER or mid-SERVE discards everything.
- Pending latch, per phase i:
  - Set at any edge where req[i]=1, except for the phase currently in SERVE.
  - Cleared at the accepting edge (OFFER and grant_ready).
  - At the phase_done edge, pending[served] <= req[served], so traffic still present re-queues.
- Wait counters:
  - +1 per cycle while pending[i]=1 and phase i is not in SERVE; saturate at 2^WAIT_W-1.
  - Cleared on acceptance of phase i.
  - aged[i] = pending[i] && wait[i] ≥ AGE_LIMIT (combinational from registers).
- Selection (combinational, evaluated only in IDLE), in priority order:
  1. preempt_valid with a valid preempt_phase → preempt_phase. A preempt also sets the pending bit of that phase.
  2. Any aged bit → lowest-index aged phase.
  3. Otherwise the first pending phase scanning upward from rr_ptr, wrapping at NPH.
  4. No candidate → stay in IDLE.
- FSM:
  - IDLE: candidate exists → OFFER at next edge with grant_valid=1 and grant_phase=winner, both registered. Latency: req high before edge k → pending after k → grant_valid after k+1.
  - OFFER: grant_valid=1 and grant_phase held stable until grant_ready=1, even if a preempt or aged phase appears meanwhile. On the grant_ready edge → SERVE, grant_valid=0, grant_phase kept.
  - SERVE: wait for phase_done. On phase_done → IDLE and rr_ptr = (grant_phase+1) mod NPH. Preempt-driven grants also advance rr_ptr.
- abort_req: in SERVE, registered high while preempt_valid with a valid preempt_phase ≠ grant_phase; cleared on phase_done or when preempt drops.
- Ignored inputs:
  - phase_done outside SERVE.
  - grant_ready outside OFFER.
- Simultaneous events:
  - phase_done and req for the same phase on the same edge → pending set per req.
  - req[i] on the acceptance edge of i → pending[i] cleared (acceptance wins).
- busy = (state != IDLE).

Test Plan:
- Single request: reset, release, req=5'b10000 one cycle → pending[4]=1 next cycle, grant_valid=1 and grant_phase=4 the cycle after; grant_ready=1 → grant_valid=0, busy=1, pending=0; phase_done → IDLE, rr_ptr=0.
- Round-robin: req=5'b11111 held, grant_ready tied 1, phase_done 3 cycles after each acceptance → grant order 0,1,2,3,4,0; each served phase re-pends after its phase_done.
- Aging: serve phase 0 with phase_done delayed 20 cycles while req[3] and req[1] are pending → both aged; next grant = 1 (lowest aged), then 3.
- Preemption: in SERVE of phase 0, preempt_valid=1, preempt_phase=4 → abort_req=1 next cycle; phase_done → abort_req=0, next grant_phase=4 even though phase 1 is pending. Repeat with preempt_phase=7 → ignored, no abort_req.
- Offer stability: in OFFER of phase 2 with grant_ready=0 for 6 cycles, assert preempt to phase 4 → grant_phase stays 2 until accepted; phase 4 is granted after phase 2's phase_done.
- Reset mid-operation: assert reset low asynchronously during SERVE (between clock edges) → grant_valid, abort_req, busy, pending and aged all 0 immediately; state=IDLE after release.
